led_sequence_scheduler: RTL

Sequences the 8-LED bank through a progressive fill / drain cycle ("sáng dần / tắt dần") from the 50 MHz system clock. An internal prescaler produces a one-cycle step strobe, so no derived clock is needed. A mode input selects the direction of each cycle, and enable pauses and resumes the pattern. The block sits between the board inputs and the `led[7:0]` pins in the top level, and replaces the divided-clock LED controller.

---
 rtl/led_sequence_scheduler.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/led_sequence_scheduler.sv
`timescale 1ns/1ps
// Progressive fill / hold / drain / hold sequencer for an 8-LED bank.
// A prescaler in the clk50M domain produces the step strobe, so no derived clock is used.
module led_sequence_scheduler #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int STEP_HZ    = 1,
  parameter int HOLD_STEPS = 2
) (
  input  logic       clk50M,
  input  logic       reset,
  input  logic       enable,
  input  logic       mode,
  output logic [7:0] led,
  output logic       tick,
  output logic       busy,
  output logic       cycle_done
);

  localparam int TICK_DIV = CLK_HZ / STEP_HZ;
  localparam int PRE_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int HOLD_W   = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS + 1) : 1;
  localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_STEPS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FILL     = 3'd1,
    S_HOLD_ON  = 3'd2,
    S_DRAIN    = 3'd3,
    S_HOLD_OFF = 3'd4
  } state_t;

  state_t              r_state;
  logic [PRE_W-1:0]    r_pre;
  logic [2:0]          r_step_cnt;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [7:0]          r_led;
  logic                r_tick;
  logic                r_pend;
  logic                r_busy;
  logic                r_cycle_done;
  logic                r_dir;
  logic                w_step;

  function automatic logic [7:0] shift_led(input logic [7:0] cur, input logic from_msb,
                                           input logic new_bit);
    return from_msb ? {new_bit, cur[7:1]} : {cur[6:0], new_bit};
  endfunction

  // A tick swallowed by a pause is remembered in r_pend and consumed on the first
  // enabled edge, so pausing on the tick cycle neither loses nor repeats a step.
  assign w_step = enable & (r_tick | r_pend);

  always_ff @(posedge clk50M) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_pre        <= '0;
      r_step_cnt   <= '0;
      r_hold_cnt   <= '0;
      r_led        <= 8'h00;
      r_tick       <= 1'b0;
      r_pend       <= 1'b0;
      r_busy       <= 1'b0;
      r_cycle_done <= 1'b0;
      r_dir        <= 1'b0;
    end else begin
      r_cycle_done <= 1'b0;
      if (r_state == S_IDLE) begin
        r_led  <= 8'h00;
        r_tick <= 1'b0;
        r_pend <= 1'b0;
        if (enable) begin
          r_state    <= S_FILL;
          r_dir      <= mode;
          r_pre      <= '0;
          r_step_cnt <= '0;
          r_hold_cnt <= '0;
          r_busy     <= 1'b1;
        end
      end else begin
        if (enable) begin
          r_pend <= 1'b0;
          if (r_pre == PRE_MAX) begin
            r_pre  <= '0;
            r_tick <= 1'b1;
          end else begin
            r_pre  <= r_pre + 1'b1;
            r_tick <= 1'b0;
          end
        end else begin
          r_tick <= 1'b0;
          r_pend <= r_pend | r_tick;
        end

        if (w_step) begin
          case (r_state)
            S_FILL: begin
              r_led      <= shift_led(r_led, r_dir, 1'b1);
              r_step_cnt <= r_step_cnt + 3'd1;
              if (r_step_cnt == 3'd7) begin
                r_step_cnt <= '0;
                r_state    <= S_HOLD_ON;
              end
            end
            S_HOLD_ON: begin
              r_hold_cnt <= r_hold_cnt + 1'b1;
              if (r_hold_cnt == HOLD_MAX) begin
                r_hold_cnt <= '0;
                r_state    <= S_DRAIN;
              end
            end
            S_DRAIN: begin
              r_led      <= shift_led(r_led, r_dir, 1'b0);
              r_step_cnt <= r_step_cnt + 3'd1;
              if (r_step_cnt == 3'd7) begin
                r_step_cnt <= '0;
                r_state    <= S_HOLD_OFF;
              end
            end
            S_HOLD_OFF: begin
              r_hold_cnt <= r_hold_cnt + 1'b1;
              if (r_hold_cnt == HOLD_MAX) begin
                r_hold_cnt   <= '0;
                r_state      <= S_FILL;
                r_dir        <= mode;
                r_cycle_done <= 1'b1;
              end
            end
            default: r_state <= S_IDLE;
          endcase
        end
      end
    end
  end

  assign led        = r_led;
  assign tick       = r_tick;
  assign busy       = r_busy;
  assign cycle_done = r_cycle_done;

endmodule
